// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, default widths
// and the ALU operation codes understood by the EXE-stage ALU.
package alu_arb_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] AND = 4'b0000;
    localparam logic [OP_W-1:0] OR  = 4'b0001;
    localparam logic [OP_W-1:0] ADD = 4'b0010;
    localparam logic [OP_W-1:0] SUB = 4'b0110;
    localparam logic [OP_W-1:0] SLT = 4'b0111;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way grant selection for the ALU arbiter. Round-robin when ALU_ARB_RR_EN
// is defined, otherwise fixed priority with req0 winning.
module alu_arb_grant (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req0_valid,
    input  logic i_req1_valid,
    input  logic i_accept,
    output logic o_grant,
    output logic o_any_valid,
    output logic o_last_grant
);

    logic r_last_grant;
    logic w_grant;

    // Reset value 1 makes req0 the preferred requester after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= w_grant;
        end
    end

`ifdef ALU_ARB_RR_EN
    assign w_grant = (i_req0_valid && i_req1_valid) ? ~r_last_grant : ~i_req0_valid;
`else
    assign w_grant = ~i_req0_valid;
`endif

    assign o_grant      = w_grant;
    assign o_any_valid  = i_req0_valid | i_req1_valid;
    assign o_last_grant = r_last_grant;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrates, holds operands
// on the ALU ports for ALU_LAT cycles, returns the captured result. Macro: ALU_ARB_RR_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = alu_arb_pkg::DATA_W,
    parameter int OP_W    = alu_arb_pkg::OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [OP_W-1:0]   ALU_operation,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              Zero,
    output logic [1:0]        o_dbg_state,
    output logic              o_dbg_last_grant
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // Requests are accepted only in IDLE; a response is held until its ready is seen.

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_gnt;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;

    logic                w_grant;
    logic                w_any_valid;
    logic                w_accept;
    logic                w_rsp_hs;

    alu_arb_grant u_grant (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req0_valid (req0_valid),
        .i_req1_valid (req1_valid),
        .i_accept     (w_accept),
        .o_grant      (w_grant),
        .o_any_valid  (w_any_valid),
        .o_last_grant (o_dbg_last_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rsp_hs     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept   = w_any_valid;
                req0_ready = w_any_valid && !w_grant;
                req1_ready = w_any_valid && w_grant;
                if (w_any_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !r_gnt;
                rsp1_valid = r_gnt;
                w_rsp_hs   = r_gnt ? rsp1_ready : rsp0_ready;
                if (w_rsp_hs) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ALU ports stay frozen from accept until the next accept, so the ALU output is stable at capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt    <= 1'b0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_gnt <= w_grant;
            r_cnt <= CNT_LOAD;
            r_op  <= w_grant ? req1_op : req0_op;
            r_a   <= w_grant ? req1_a  : req0_a;
            r_b   <= w_grant ? req1_b  : req0_b;
        end else if (r_state == ISSUE) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_result <= ALU_result;
                r_zero   <= Zero;
            end
        end
    end

    assign ALU_operation = r_op;
    assign A             = r_a;
    assign B             = r_b;
    assign rsp_result    = r_result;
    assign rsp_zero      = r_zero;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3), each with a
// behavioural ALU, a per-cycle reference model and a table of hand-computed results.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DW     = 32;
  localparam int OW     = 4;
  localparam int CW     = DW + 1;
  localparam int BUDGET = 60;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          has;
    logic          gnt;
    logic [DW-1:0] res;
    logic          zero;
    logic [3:0]    lat;
  } lit_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // per-instance signals, index [inst][requester]
  logic          v[2][2];
  logic          rdy[2][2];
  logic [OW-1:0] op[2][2];
  logic [DW-1:0] ra[2][2];
  logic [DW-1:0] rb[2][2];
  logic          rsv[2][2];
  logic          rsr[2][2];
  logic [DW-1:0] rsp_result[2];
  logic          rsp_zero[2];
  logic [OW-1:0] alu_op[2];
  logic [DW-1:0] alu_a[2];
  logic [DW-1:0] alu_b[2];
  logic [1:0]    dbg_state[2];
  logic          dbg_last[2];

  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] o, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (o)
      AND:     return a & b;
      OR:      return a | b;
      ADD:     return a + b;
      SUB:     return a - b;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] w_res;
    logic          w_zero;
    assign w_res  = alu_f(alu_op[g], alu_a[g], alu_b[g]);
    assign w_zero = (w_res == '0);
    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .ALU_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .req0_valid       (v[g][0]),
      .req0_ready       (rdy[g][0]),
      .req0_op          (op[g][0]),
      .req0_a           (ra[g][0]),
      .req0_b           (rb[g][0]),
      .req1_valid       (v[g][1]),
      .req1_ready       (rdy[g][1]),
      .req1_op          (op[g][1]),
      .req1_a           (ra[g][1]),
      .req1_b           (rb[g][1]),
      .rsp0_valid       (rsv[g][0]),
      .rsp0_ready       (rsr[g][0]),
      .rsp1_valid       (rsv[g][1]),
      .rsp1_ready       (rsr[g][1]),
      .rsp_result       (rsp_result[g]),
      .rsp_zero         (rsp_zero[g]),
      .ALU_operation    (alu_op[g]),
      .A                (alu_a[g]),
      .B                (alu_b[g]),
      .ALU_result       (w_res),
      .Zero             (w_zero),
      .o_dbg_state      (dbg_state[g]),
      .o_dbg_last_grant (dbg_last[g])
    );
  end

  // scoreboard state (written only by the compare process)
  int            n_pass = 0;
  int            n_total = 0;
  logic          m_busy[2];
  logic          m_gnt[2];
  logic [DW:0]   m_exp[2];
  int            m_due[2];
  logic [OW-1:0] m_op[2];
  logic [DW-1:0] m_a[2];
  logic [DW-1:0] m_b[2];
  logic          m_last[2];
  int            n_acc[2];
  int            acc_cyc[2];
  logic          prev_dv[2];
  int            tmo_seen = 0;
  logic          final_done = 1'b0;

  // written only by the stimulus process
  lit_t lit[2][16];
  int   n_tmo = 0;
  logic final_chk = 1'b0;

  task automatic chk(input string nm, input int i, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", nm, i, act, exp, cyc);
  endtask

  // compare process
  always @(negedge clk) begin
    logic busy, e_r0, e_r1, due, dut_v, g;
    int   lat_i, k;
    for (int i = 0; i < 2; i++) begin
      lat_i = (i == 0) ? 1 : 3;
      if (reset) begin
        chk("rst_rdy0", i, CW'(rdy[i][0]), CW'(0));
        chk("rst_rdy1", i, CW'(rdy[i][1]), CW'(0));
        chk("rst_rsv0", i, CW'(rsv[i][0]), CW'(0));
        chk("rst_rsv1", i, CW'(rsv[i][1]), CW'(0));
        chk("rst_result", i, CW'(rsp_result[i]), CW'(0));
        chk("rst_zero", i, CW'(rsp_zero[i]), CW'(0));
        chk("rst_op", i, CW'(alu_op[i]), CW'(0));
        chk("rst_a", i, CW'(alu_a[i]), CW'(0));
        chk("rst_b", i, CW'(alu_b[i]), CW'(0));
        chk("rst_state", i, CW'(dbg_state[i]), CW'(IDLE));
        chk("rst_last", i, CW'(dbg_last[i]), CW'(1));
        m_busy[i]  = 1'b0;
        m_gnt[i]   = 1'b0;
        m_exp[i]   = '0;
        m_due[i]   = 0;
        m_op[i]    = '0;
        m_a[i]     = '0;
        m_b[i]     = '0;
        m_last[i]  = 1'b1;
        prev_dv[i] = 1'b0;
      end else begin
        busy = m_busy[i];
        e_r0 = !busy && v[i][0] && (RR ? !(v[i][1] && !m_last[i]) : 1'b1);
        e_r1 = !busy && v[i][1] && (RR ? !(v[i][0] && m_last[i]) : !v[i][0]);
        chk("ready0", i, CW'(rdy[i][0]), CW'(e_r0));
        chk("ready1", i, CW'(rdy[i][1]), CW'(e_r1));
        due = busy && (cyc >= m_due[i]);
        chk("rsp0_valid", i, CW'(rsv[i][0]), CW'(due && !m_gnt[i]));
        chk("rsp1_valid", i, CW'(rsv[i][1]), CW'(due && m_gnt[i]));
        if (due) begin
          chk("rsp_result", i, CW'(rsp_result[i]), CW'(m_exp[i][DW-1:0]));
          chk("rsp_zero", i, CW'(rsp_zero[i]), CW'(m_exp[i][DW]));
        end
        chk("alu_op", i, CW'(alu_op[i]), CW'(m_op[i]));
        chk("alu_a", i, CW'(alu_a[i]), CW'(m_a[i]));
        chk("alu_b", i, CW'(alu_b[i]), CW'(m_b[i]));
        // hand-computed expectations, checked on the first cycle the DUT offers a response
        dut_v = rsv[i][0] | rsv[i][1];
        if (dut_v && !prev_dv[i]) begin
          k = n_acc[i] - 1;
          if (k >= 0 && k < 16 && lit[i][k].has) begin
            chk("lit_gnt", i, CW'(rsv[i][1]), CW'(lit[i][k].gnt));
            chk("lit_result", i, CW'(rsp_result[i]), CW'(lit[i][k].res));
            chk("lit_zero", i, CW'(rsp_zero[i]), CW'(lit[i][k].zero));
            chk("lit_latency", i, CW'(cyc - acc_cyc[i]), CW'(lit[i][k].lat));
          end
        end
        prev_dv[i] = dut_v;
        if (due && rsr[i][m_gnt[i]]) begin
          m_busy[i] = 1'b0;
        end else if (e_r0 || e_r1) begin
          g          = e_r1;
          m_busy[i]  = 1'b1;
          m_gnt[i]   = g;
          m_exp[i]   = {(alu_f(op[i][g], ra[i][g], rb[i][g]) == '0),
                        alu_f(op[i][g], ra[i][g], rb[i][g])};
          m_due[i]   = cyc + 1 + lat_i;
          m_op[i]    = op[i][g];
          m_a[i]     = ra[i][g];
          m_b[i]     = rb[i][g];
          m_last[i]  = g;
          acc_cyc[i] = cyc;
          n_acc[i]   = n_acc[i] + 1;
        end
      end
    end
    if (n_tmo != tmo_seen) begin
      n_total++;
      $display("FAIL timeout: %0d waits expired, required 0", n_tmo);
      tmo_seen = n_tmo;
    end
    if (final_chk && !final_done) begin
      chk("accept_count", 0, CW'(n_acc[0]), CW'(14));
      chk("accept_count", 1, CW'(n_acc[1]), CW'(2));
      final_done = 1'b1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int r, input logic [OW-1:0] o,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    v[i][r]  = 1'b1;
    op[i][r] = o;
    ra[i][r] = a;
    rb[i][r] = b;
  endtask

  task automatic wait_hs(input int i, input int r);
    logic hs;
    hs = 1'b0;
    for (int t = 0; t < BUDGET && !hs; t++) begin
      @(negedge clk);
      hs = v[i][r] && rdy[i][r];
      tick();
    end
    v[i][r] = 1'b0;
    if (!hs) n_tmo++;
  endtask

  task automatic wait_rsp(input int i, input int r, input bit need_ready);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < BUDGET && !seen; t++) begin
      @(negedge clk);
      seen = rsv[i][r] && (rsr[i][r] || !need_ready);
      tick();
    end
    if (!seen) n_tmo++;
  endtask

  task automatic do_op(input int i, input int r, input logic [OW-1:0] o,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_req(i, r, o, a, b);
    wait_hs(i, r);
    wait_rsp(i, r, 1'b1);
  endtask

  task automatic set_lit(input int i, input int k, input logic g, input logic [DW-1:0] res,
                         input logic z, input logic [3:0] lat);
    lit[i][k] = '{has: 1'b1, gnt: g, res: res, zero: z, lat: lat};
  endtask

  // stimulus
  initial begin
    int   k0, k1;
    logic h0, h1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) lit[i][k] = '0;
      for (int r = 0; r < 2; r++) begin
        v[i][r] = 1'b0; op[i][r] = '0; ra[i][r] = '0; rb[i][r] = '0; rsr[i][r] = 1'b1;
      end
    end
    set_lit(0, 0, 1'b0, 32'd12, 1'b0, 4'd2);
    set_lit(0, 1, 1'b1, 32'd0, 1'b1, 4'd2);
    for (int k = 0; k < 4; k++) begin
      if (RR) begin
        set_lit(0, 2 + 2 * k, 1'b0, 32'd11 + k, 1'b0, 4'd2);
        set_lit(0, 3 + 2 * k, 1'b1, 32'h80 | (32'd1 << k), 1'b0, 4'd2);
      end else begin
        set_lit(0, 2 + k, 1'b0, 32'd11 + k, 1'b0, 4'd2);
        set_lit(0, 6 + k, 1'b1, 32'h80 | (32'd1 << k), 1'b0, 4'd2);
      end
    end
    set_lit(0, 10, 1'b0, 32'h0F000F00, 1'b0, 4'd2);
    set_lit(0, 11, 1'b1, 32'd17, 1'b0, 4'd2);
    set_lit(0, 13, 1'b0, 32'hFF, 1'b0, 4'd2);
    set_lit(1, 0, 1'b0, 32'd1, 1'b0, 4'd4);
    set_lit(1, 1, 1'b1, 32'd0, 1'b1, 4'd4);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // single requests on each port
    do_op(0, 0, ADD, 32'd5, 32'd7);
    do_op(0, 1, SUB, 32'd9, 32'd9);

    // both requesters valid continuously, four ops each
    k0 = 0;
    k1 = 0;
    set_req(0, 0, ADD, 32'd1, 32'd10);
    set_req(0, 1, OR, 32'd1, 32'h80);
    for (int t = 0; t < 200 && (k0 < 4 || k1 < 4); t++) begin
      @(negedge clk);
      h0 = v[0][0] && rdy[0][0];
      h1 = v[0][1] && rdy[0][1];
      tick();
      if (h0) begin
        k0++;
        if (k0 < 4) set_req(0, 0, ADD, 32'(k0 + 1), 32'd10);
        else v[0][0] = 1'b0;
      end
      if (h1) begin
        k1++;
        if (k1 < 4) set_req(0, 1, OR, 32'd1 << k1, 32'h80);
        else v[0][1] = 1'b0;
      end
    end
    if (k0 < 4 || k1 < 4) n_tmo++;
    v[0][0] = 1'b0;
    v[0][1] = 1'b0;
    wait_rsp(0, 1, 1'b1);

    // response backpressure with the other requester waiting
    rsr[0][0] = 1'b0;
    set_req(0, 0, AND, 32'hFF00FF00, 32'h0FF00FF0);
    set_req(0, 1, SUB, 32'd20, 32'd3);
    wait_hs(0, 0);
    wait_rsp(0, 0, 1'b0);
    repeat (5) tick();
    rsr[0][0] = 1'b1;
    wait_rsp(0, 0, 1'b1);
    wait_hs(0, 1);
    wait_rsp(0, 1, 1'b1);

    // reset pulse while the operation is in ISSUE
    set_req(0, 0, ADD, 32'd1, 32'd2);
    wait_hs(0, 0);
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    tick();
    do_op(0, 0, OR, 32'hF0, 32'h0F);

    // longer ALU latency instance
    do_op(1, 0, SLT, 32'hFFFFFFFF, 32'd2);
    do_op(1, 1, SLT, 32'd5, 32'hFFFFFFFD);

    repeat (2) tick();
    final_chk = 1'b1;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
